// File: rtl/mram_req_arbiter_if.sv
// Requester-side and MRAM-side signal bundle for mram_req_arbiter.
// MRAM_REQ_ARB_STATS_EN adds the per-port grant and conflict counters.
interface mram_req_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2:0]        req0_op;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [2:0]        req1_op;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [2:0]        sel;
    logic              ser_addr;
    logic              ser_data;
    logic              ser_rdata;
    logic              busy;
`ifdef MRAM_REQ_ARB_STATS_EN
    logic [15:0]       grant_cnt0;
    logic [15:0]       grant_cnt1;
    logic [15:0]       conflict_cnt;

    modport slave (
        input  req_valid, req0_op, req0_addr, req0_wdata,
               req1_op, req1_addr, req1_wdata, ser_rdata,
        output req_ready, rsp_valid, rsp_rdata, sel, ser_addr, ser_data, busy,
               grant_cnt0, grant_cnt1, conflict_cnt
    );
    modport master (
        output req_valid, req0_op, req0_addr, req0_wdata,
               req1_op, req1_addr, req1_wdata, ser_rdata,
        input  req_ready, rsp_valid, rsp_rdata, sel, ser_addr, ser_data, busy,
               grant_cnt0, grant_cnt1, conflict_cnt
    );
`else
    modport slave (
        input  req_valid, req0_op, req0_addr, req0_wdata,
               req1_op, req1_addr, req1_wdata, ser_rdata,
        output req_ready, rsp_valid, rsp_rdata, sel, ser_addr, ser_data, busy
    );
    modport master (
        output req_valid, req0_op, req0_addr, req0_wdata,
               req1_op, req1_addr, req1_wdata, ser_rdata,
        input  req_ready, rsp_valid, rsp_rdata, sel, ser_addr, ser_data, busy
    );
`endif
endinterface

// File: rtl/mram_req_arbiter.sv
// Round-robin two-port arbiter that serialises one request at a time onto the MRAM command path.
// Latency: nop 1, write FRAME_LEN+1, read FRAME_LEN+RD_LAT+N+1; stats counters under MRAM_REQ_ARB_STATS_EN.
module mram_req_arbiter #(
    parameter int FRAME_LEN = 22,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 2
) (
    input logic              clk,
    input logic              rst,
    mram_req_arbiter_if.slave bus_if
);
    localparam int HALF_W  = DATA_W / 2;
    localparam int CNT_MX1 = (FRAME_LEN > DATA_W) ? FRAME_LEN : DATA_W;
    localparam int CNT_MAX = (CNT_MX1 > RD_LAT) ? CNT_MX1 : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FRAME  = 3'd1,
        S_RDWAIT = 3'd2,
        S_RDCAP  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rr_ptr;
    logic                r_owner;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr_sh;
    logic [DATA_W-1:0]   r_data_sh;
    logic [DATA_W-2:0]   r_cap;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_owner;
    logic [2:0]          w_in_op;
    logic [ADDR_W-1:0]   w_in_addr;
    logic [DATA_W-1:0]   w_in_wdata;
    logic                w_frame_end;
    logic                w_wait_end;
    logic                w_cap_last;
    logic [DATA_W-1:0]   w_cap_final;
    logic [DATA_W-1:0]   w_lane;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        w_grant = bus_if.req_valid;
        if (bus_if.req_valid == 2'b11)
            w_grant = r_rr_ptr ? 2'b10 : 2'b01;
    end

    assign w_accept   = (r_state == S_IDLE) && (w_grant != 2'b00);
    assign w_owner    = w_grant[1];
    assign w_in_op    = w_owner ? bus_if.req1_op    : bus_if.req0_op;
    assign w_in_addr  = w_owner ? bus_if.req1_addr  : bus_if.req0_addr;
    assign w_in_wdata = w_owner ? bus_if.req1_wdata : bus_if.req0_wdata;

    assign w_frame_end = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_wait_end  = (r_cnt == CNT_W'(RD_LAT - 1));
    assign w_cap_last  = (r_op[2:1] == 2'b11) ? (r_cnt == CNT_W'(DATA_W - 1))
                                              : (r_cnt == CNT_W'(HALF_W - 1));
    assign w_cap_final = {r_cap, bus_if.ser_rdata};

    always_comb begin
        w_lane = w_cap_final;
        if (r_op[2:1] == 2'b01)
            w_lane = {{(DATA_W-HALF_W){1'b0}}, w_cap_final[HALF_W-1:0]};
        else if (r_op[2:1] == 2'b10)
            w_lane = {w_cap_final[HALF_W-1:0], {(DATA_W-HALF_W){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        bus_if.req_ready = 2'b00;
        bus_if.rsp_valid = 2'b00;
        bus_if.sel       = 3'b000;
        bus_if.ser_addr  = 1'b0;
        bus_if.ser_data  = 1'b0;
        bus_if.busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                bus_if.req_ready = w_grant;
                if (w_accept)
                    w_next = (w_in_op[2:1] == 2'b00) ? S_RESP : S_FRAME;
            end
            S_FRAME: begin
                bus_if.sel      = r_op;
                bus_if.ser_addr = r_addr_sh[ADDR_W-1];
                bus_if.ser_data = r_data_sh[DATA_W-1];
                if (w_frame_end)
                    w_next = r_op[0] ? S_RESP : S_RDWAIT;
            end
            S_RDWAIT: if (w_wait_end) w_next = S_RDCAP;
            S_RDCAP:  if (w_cap_last) w_next = S_RESP;
            S_RESP: begin
                bus_if.rsp_valid = r_owner ? 2'b10 : 2'b01;
                w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rr_ptr  <= 1'b0;
            r_owner   <= 1'b0;
            r_op      <= '0;
            r_addr_sh <= '0;
            r_data_sh <= '0;
            r_cap     <= '0;
            r_rdata   <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (w_accept) begin
                r_owner   <= w_owner;
                r_rr_ptr  <= ~w_owner;
                r_op      <= w_in_op;
                r_addr_sh <= w_in_addr;
                // Reads shift zeros so ser_data stays low without a separate gate.
                r_data_sh <= w_in_op[0] ? w_in_wdata : '0;
                r_cap     <= '0;
            end
            if (r_state == S_FRAME) begin
                r_addr_sh <= {r_addr_sh[ADDR_W-2:0], 1'b0};
                r_data_sh <= {r_data_sh[DATA_W-2:0], 1'b0};
            end
            if (r_state == S_RDCAP)
                r_cap <= w_cap_final[DATA_W-2:0];
            if ((w_next == S_RESP) && (r_state != S_RESP))
                r_rdata <= (r_state == S_RDCAP) ? w_lane : '0;
        end
    end

    assign bus_if.rsp_rdata = r_rdata;

`ifdef MRAM_REQ_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt0   <= '0;
            r_grant_cnt1   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_accept && !w_owner && (r_grant_cnt0 != 16'hFFFF))
                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            if (w_accept && w_owner && (r_grant_cnt1 != 16'hFFFF))
                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            if ((r_state == S_IDLE) && (bus_if.req_valid == 2'b11) && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign bus_if.grant_cnt0   = r_grant_cnt0;
    assign bus_if.grant_cnt1   = r_grant_cnt1;
    assign bus_if.conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_mram_req_arbiter.sv
// Randomised bench for mram_req_arbiter against a transaction-level reference model.
module tb_mram_req_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mram_req_arbiter_if bus ();
    mram_req_arbiter dut (.clk(clk), .rst(rst), .bus_if(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending request per port, as a requester would hold it.
    bit          pv   [2];
    logic [2:0]  pop  [2];
    logic [19:0] padr [2];
    logic [15:0] pwd  [2];
    int          model_ptr;
    logic [15:0] last_rdata;
    int          acc  [2];
    int          conf;

    task automatic drive();
        bus.req_valid  = {pv[1], pv[0]};
        bus.req0_op    = pop[0];
        bus.req0_addr  = padr[0];
        bus.req0_wdata = pwd[0];
        bus.req1_op    = pop[1];
        bus.req1_addr  = padr[1];
        bus.req1_wdata = pwd[1];
    endtask

    task automatic set_req(input int p, input logic [2:0] op, input logic [19:0] a, input logic [15:0] d);
        pv[p] = 1'b1; pop[p] = op; padr[p] = a; pwd[p] = d;
    endtask

    task automatic rand_req(input int p);
        logic [2:0] op;
        op = 3'($urandom);
        if (op[2:1] == 2'b00 && $urandom_range(0, 2) != 0) op[2] = 1'b1;
        set_req(p, op, 20'($urandom), 16'($urandom));
    endtask

    // Entered at posedge+1 of an idle cycle with at least one port pending; returns likewise.
    task automatic run_txn(input logic [15:0] rword);
        logic [1:0]  expg;
        int          own, lat, nbits, k;
        logic [2:0]  op;
        logic [1:0]  mask;
        logic [19:0] a;
        logic [15:0] d, exp_rd;
        logic        esa, esd;
        drive();
        @(negedge clk);
        if (pv[0] && pv[1]) expg = (model_ptr == 1) ? 2'b10 : 2'b01;
        else                expg = {pv[1], pv[0]};
        check("req_ready", 32'(bus.req_ready), 32'(expg));
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("rdata_hold", 32'(bus.rsp_rdata), 32'(last_rdata));
        if (pv[0] && pv[1]) conf++;
        own = expg[1] ? 1 : 0;
        op = pop[own]; a = padr[own]; d = pwd[own];
        mask = op[2:1];
        @(posedge clk); #1;
        model_ptr = 1 - own;
        acc[own]++;
        pv[own] = 1'b0;
        drive();
        nbits = (mask == 2'b11) ? 16 : 8;
        if (mask == 2'b00)  begin lat = 1;  exp_rd = 16'h0; end
        else if (op[0])     begin lat = 23; exp_rd = 16'h0; end
        else if (mask == 2'b11) begin lat = 41; exp_rd = rword; end
        else if (mask == 2'b01) begin lat = 33; exp_rd = {8'h00, rword[7:0]}; end
        else                begin lat = 33; exp_rd = {rword[7:0], 8'h00}; end
        for (k = 1; k <= lat; k++) begin
            if (k >= 25 && k < 25 + nbits) bus.ser_rdata = rword[nbits - 1 - (k - 25)];
            else                           bus.ser_rdata = 1'($urandom);
            @(negedge clk);
            esa = (mask != 2'b00 && k <= 20) ? a[20 - k] : 1'b0;
            esd = (mask != 2'b00 && op[0] && k <= 16) ? d[16 - k] : 1'b0;
            check("sel", 32'(bus.sel), (mask != 2'b00 && k <= 22) ? 32'(op) : 32'd0);
            check("ser_addr", 32'(bus.ser_addr), 32'(esa));
            check("ser_data", 32'(bus.ser_data), 32'(esd));
            check("rsp_valid", 32'(bus.rsp_valid), (k == lat) ? (own == 1 ? 32'd2 : 32'd1) : 32'd0);
            check("busy", 32'(bus.busy), 32'd1);
            check("ready_busy", 32'(bus.req_ready), 32'd0);
            if (k == lat) begin
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
                last_rdata = exp_rd;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_stats();
`ifdef MRAM_REQ_ARB_STATS_EN
        check("grant_cnt0", 32'(bus.grant_cnt0), 32'(acc[0]));
        check("grant_cnt1", 32'(bus.grant_cnt1), 32'(acc[1]));
        check("conflict_cnt", 32'(bus.conflict_cnt), 32'(conf));
`endif
    endtask

    initial begin
        pv[0] = 0; pv[1] = 0;
        for (int p = 0; p < 2; p++) begin pop[p] = '0; padr[p] = '0; pwd[p] = '0; acc[p] = 0; end
        model_ptr = 0; last_rdata = '0; conf = 0;
        bus.ser_rdata = 1'b0;
        drive();
        rst = 1'b1;
        #1;
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        set_req(0, 3'b111, 20'hABCDE, 16'h1234); run_txn(16'h0);
        set_req(1, 3'b110, 20'h00010, 16'h0);    run_txn(16'hBEEF);
        set_req(0, 3'b010, 20'h00020, 16'h0);    run_txn(16'h005A);
        set_req(0, 3'b100, 20'h00030, 16'h0);    run_txn(16'h005A);
        set_req(1, 3'b000, 20'h00040, 16'hFFFF); run_txn(16'hFFFF);

        // Abort a read in the middle of its frame.
        set_req(0, 3'b110, 20'h12345, 16'h0);
        drive();
        @(negedge clk);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        pv[0] = 0; drive();
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_sel", 32'(bus.sel), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rsp", 32'(bus.rsp_valid), 32'd0);
        model_ptr = 0; last_rdata = '0; acc[0] = 0; acc[1] = 0; conf = 0;
        repeat (2) begin
            @(negedge clk);
            check("abort_rsp_hold", 32'(bus.rsp_valid), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Both ports continuously valid: grants alternate from port0.
        rand_req(0); rand_req(1);
        for (int i = 0; i < 4; i++) begin
            run_txn(16'($urandom));
            if (!pv[0]) rand_req(0);
            if (!pv[1]) rand_req(1);
        end
        check_stats();

        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(0, 3) != 0) rand_req(p);
            if (!pv[0] && !pv[1]) rand_req($urandom_range(0, 1));
            run_txn(16'($urandom));
        end
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mram_req_arbiter.md
Name: mram_req_arbiter

Overview:
- Shares the single serial MRAM access path between two requester ports, using round-robin arbitration.
- Accepts one parallel request at a time and serializes its address and write data into a fixed-length command frame.
- For reads, collects the serial read-back data into a 16-bit response.
- Sits upstream of the MRAM control/STP/PTS datapath and drives its 3-bit read_write_sel and serial address/data lines.

Parameters:
- FRAME_LEN, 22: cycles per command frame; sel is held for this many cycles.
- ADDR_W, 20: address width, shifted out MSB-first.
- DATA_W, 16: data width, shifted out MSB-first.
- RD_LAT, 2: idle cycles between frame end and the first read-data sample.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port accept; one-hot or zero
- req0_op  in  3  port0 op: bit0 1=write/0=read; bits2:1 byte mask, 01 lower, 10 upper, 11 full, 00 nop
- req0_addr  in  ADDR_W  port0 address
- req0_wdata  in  DATA_W  port0 write data
- req1_op, req1_addr, req1_wdata  in  3/ADDR_W/DATA_W  port1 equivalents
- rsp_valid  out  2  one-cycle completion pulse to the owning port
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- sel  out  3  read_write_sel to the MRAM control block
- ser_addr  out  1  serial address bit
- ser_data  out  1  serial write-data bit
- ser_rdata  in  1  serial read data returned from the MRAM
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0 (port0 favoured first).
- States: IDLE, FRAME, RDWAIT, RDCAP, RESP.
- IDLE: req_ready is combinational; for each port, req_ready[p] = (state==IDLE) && grant[p].
  - Grant rule: if only one port is valid, grant it. If both are valid, grant port rr_ptr.
  - Accept cycle A is the cycle with req_valid & req_ready. In A: latch op/addr/wdata and owner id, set rr_ptr = ~owner, go to FRAME with cnt=0.
  - Requesters hold their inputs stable while valid until accepted.
- Nop (mask 00): accepted normally, no frame issued, go directly to RESP. rsp_valid at A+1, rsp_rdata=0.
- FRAME: occupies cycles A+1..A+FRAME_LEN, with cnt counting 0..FRAME_LEN-1.
  - sel = latched op for the whole frame.
  - ser_addr = addr[ADDR_W-1-cnt] for cnt<ADDR_W, else 0.
  - ser_data = wdata[DATA_W-1-cnt] for cnt<DATA_W, and only for writes; otherwise 0.
  - At cnt=FRAME_LEN-1: a write goes to RESP; a read goes to RDWAIT.
  - Outside FRAME, sel/ser_addr/ser_data are 0.
- RDWAIT: RD_LAT cycles, cnt counts 0..RD_LAT-1, then go to RDCAP.
- RDCAP: N sample cycles, with N=DATA_W for mask 11 and N=DATA_W/2 otherwise.
  - Sample ser_rdata at each rising edge and shift MSB-first into the capture register.
  - Half-word result is placed in its lane: mask 01 → bits 7:0, mask 10 → bits 15:8. The other lane is 0.
- RESP: one cycle. rsp_valid[owner]=1, rsp_rdata = captured data (0 for writes). Next state IDLE.
- Latency from A to rsp_valid:
  - write: A+FRAME_LEN+1 (23)
  - full read: A+FRAME_LEN+RD_LAT+17 (41)
  - half read: A+33
  - nop: A+1
- New accept is possible no earlier than the cycle after RESP.
- rsp_rdata holds its value until the next RESP; it is not cleared.
- Reset mid-operation: abort immediately. Everything returns to reset values; the in-flight request gets no rsp_valid.
- Port id is not observable on a shared bus; each rsp_valid bit goes only to its owner.

Optional Feature:
- Macro MRAM_REQ_ARB_STATS_EN.
- When defined, adds outputs grant_cnt0 and grant_cnt1 (16 bits each): per-port accept counters.
  - Increment on accept, saturate at 16'hFFFF, clear on rst.
  - Also adds output conflict_cnt (16 bits, saturating): increments in IDLE when both req_valid are high.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Port0 write op=3'b111, addr=20'hABCDE, wdata=16'h1234 → ser_addr serializes ABCDE during A+1..A+20; ser_data serializes 1234 during A+1..A+16; sel=3'b111 for 22 cycles; rsp_valid[0] at A+23.
- Port1 full read op=3'b110, addr=20'h00010, ser_rdata driven with 16'hBEEF from A+25..A+40 → rsp_valid[1] at A+41, rsp_rdata=16'hBEEF.
- Port0 lower read op=3'b010, ser_rdata=8'h5A over A+25..A+32 → rsp_valid[0] at A+33, rsp_rdata=16'h005A. Upper read op=3'b100 with the same data → rsp_rdata=16'h5A00.
- Both ports continuously valid → grants alternate 0,1,0,1; req_ready never 2'b11. With stats enabled: grant_cnt0=grant_cnt1=2 after 4 requests.
- Nop op=3'b000 on port1 → no sel activity, rsp_valid[1] at A+1, rsp_rdata=0.
- rst asserted at A+10 of a read → outputs 0 immediately, no rsp_valid; next request accepted with port0 favoured.
